tx_packet_arbiter: RTL and testbench
====================================

Name: tx_packet_arbiter

Overview:
- Shares the single USB upstream TX FIFO write port between three word sources: 0 = SPIROC readout socket, 1 = configuration echo, 2 = HV UART reply.
- Grants whole packets round-robin. Frames each packet as header, length, payload and trailer.
- Pads truncated packets after a starvation timeout so the host parser never desynchronises.
- Sits between the per-source FIFOs and the TX FIFO that feeds the FX2 slave-FIFO driver. Runs in the 40 MHz system domain.

Parameters:
- HDR_BASE, 16'hA5A0, header word; the source id is ORed into bits [1:0].
- TRL_OK, 16'h5A5A, trailer word for a complete packet.
- TRL_ERR, 16'h5A5B, trailer word for a padded (timed-out) packet.
- PAD_WORD, 16'hDEAD, filler word written for missing payload.
- TIMEOUT, 1024, consecutive cycles a granted source may stay empty before padding starts.

Ports:
- clk  in  1  system clock, 40 MHz.
- rst  in  1  synchronous, active-high reset.
- src_req  in  3  per source: packet ready; level, held until src_done.
- src_len  in  36  per source 12-bit payload word count, packed {s2,s1,s0}; must be stable while src_req is high.
- src_empty  in  3  per-source FIFO empty.
- src_rd_en  out  3  per-source FIFO read strobe.
- src_valid  in  3  per-source read data valid, exactly 1 cycle after src_rd_en.
- src_data  in  48  per-source 16-bit read data, packed {s2,s1,s0}.
- src_done  out  3  one-cycle pulse when a source's packet trailer is written.
- out_full  in  1  TX FIFO full.
- out_wr_en  out  1  TX FIFO write strobe.
- out_data  out  16  TX FIFO write data.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky; set on any padding; cleared only by rst.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, round-robin pointer last = 2 (so source 0 wins first), counters 0, holding register empty.
- Arbitration in IDLE: search order last+1, last+2, last (mod 3). The first source with src_req high is granted.
  - On grant: latch id and len, set last = id, go to HDR. Grant takes 1 cycle.
  - A request arriving mid-packet waits. No preemption.
- Write rule: out_wr_en = 1 only when out_full = 0. A state holding a word stays put while out_full = 1, with out_data stable.
- HDR: write HDR_BASE | id, then go to LEN.
- LEN: write {4'h0, len}. If len == 0, go to TRL; otherwise go to PAY.
- PAY: reads and writes overlap through a 1-word holding register.
  - src_rd_en[id] = 1 when all hold: reads_left > 0, src_empty[id] = 0, holding register empty, no read outstanding.
  - The word is captured on src_valid[id] and written when out_full = 0.
  - Peak rate is 1 word per 2 cycles. Exactly len reads are issued; no read is ever issued to a non-granted source.
- Starvation:
  - The counter increments each PAY cycle where src_empty[id] = 1 and a read is wanted; it clears on any read.
  - At count == TIMEOUT the block enters padding mode: no more reads, each remaining word is written as PAD_WORD (subject to out_full), and err_timeout is set.
  - In padding mode, src_empty deasserting has no effect.
- TRL: write TRL_ERR if padded, else TRL_OK. Go to DONE.
- DONE: pulse src_done[id] for 1 cycle, return to IDLE. The source must drop src_req by the next cycle or it re-enters arbitration as a new packet.
- src_valid outside an outstanding read is ignored.
- src_req dropping after grant is ignored; the packet completes (with padding if the data is gone).
- rst asserted mid-packet aborts immediately with no trailer. The host relies on header resync.
- Packet length on the bus = len + 3 words. Internal counters are 12-bit; len = 4095 is legal with no wrap.

Test Plan:
- Single packet: src0 req, len = 4, FIFO holds 1,2,3,4, out_full = 0 → out_data A5A0, 0004, 0001..0004, 5A5A; src_done[0] pulses once; 4 src_rd_en[0] strobes.
- Round robin: all three req with len = 1 from reset → headers in order A5A0, A5A1, A5A2. src0 re-requests during src2's packet → src0 is served after src2.
- Backpressure: out_full held high 10 cycles during PAY → out_data frozen, no write, no extra src_rd_en; data order intact after release.
- Zero length: src1 req, len = 0 → A5A1, 0000, 5A5A; no src_rd_en[1].
- Timeout: src2 len = 5, supplies 2 words then stays empty; TIMEOUT = 16 → 2 data words, 3×DEAD, 5A5B; err_timeout = 1 stays high until rst.
- Reset mid-PAY, then re-request → all outputs 0 within 1 cycle; next grant goes to source 0; fresh header.

Source files
------------

// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter: round-robin packet framer sharing one TX FIFO write port between three sources
module tx_packet_arbiter #(
  parameter logic [15:0] HDR_BASE = 16'hA5A0,
  parameter logic [15:0] TRL_OK   = 16'h5A5A,
  parameter logic [15:0] TRL_ERR  = 16'h5A5B,
  parameter logic [15:0] PAD_WORD = 16'hDEAD,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  src_req,
  input  logic [35:0] src_len,
  input  logic [2:0]  src_empty,
  output logic [2:0]  src_rd_en,
  input  logic [2:0]  src_valid,
  input  logic [47:0] src_data,
  output logic [2:0]  src_done,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, HDR, LEN, PAY, TRL, DONE} state_t;
  state_t state;
  logic [1:0] id, last, c1, c2, pick;
  logic [11:0] len, reads_left, writes_left;
  logic [CW-1:0] starve;
  logic [15:0] hold_data;
  logic hold_valid, outstanding, pad, starved, word_ok, wr, want, rd;
  assign c1 = last == 2'd2 ? 2'd0 : last + 2'd1;
  assign c2 = last == 2'd0 ? 2'd2 : last - 2'd1;
  assign pick = src_req[c1] ? c1 : src_req[c2] ? c2 : last;
  assign starved = starve == CW'(TIMEOUT);
  assign word_ok = state == HDR || state == LEN || state == TRL || (state == PAY && (hold_valid || pad));
  assign wr = word_ok && !out_full;
  // a read may be issued in the same cycle the holding register drains, giving 1 word per 2 cycles
  assign want = state == PAY && !pad && !starved && reads_left != 12'd0 && !outstanding && (!hold_valid || wr);
  assign rd = want && !src_empty[id];
  assign src_rd_en = 3'(rd) << id;
  assign src_done = 3'(state == DONE) << id;
  assign busy = state != IDLE;
  assign out_wr_en = wr;
  always_comb
    out_data = state == HDR ? (HDR_BASE | {14'd0, id}) :
               state == LEN ? {4'h0, len} :
               state == PAY ? (pad ? PAD_WORD : hold_data) :
               state == TRL ? (pad ? TRL_ERR : TRL_OK) : 16'h0000;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 2'd2;
      id <= 2'd0;
      len <= 12'd0;
      reads_left <= 12'd0;
      writes_left <= 12'd0;
      starve <= '0;
      hold_data <= 16'h0000;
      hold_valid <= 1'b0;
      outstanding <= 1'b0;
      pad <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      outstanding <= rd;
      if (outstanding && src_valid[id]) begin
        hold_valid <= 1'b1;
        hold_data <= src_data[16*id +: 16];
      end else if (wr && state == PAY) hold_valid <= 1'b0;
      if (rd) begin
        reads_left <= reads_left - 12'd1;
        starve <= '0;
      end else if (want) starve <= starve + CW'(1);
      if (state == PAY && starved) begin
        pad <= 1'b1;
        err_timeout <= 1'b1;
      end
      case (state)
        IDLE: if (|src_req) begin
          id <= pick;
          last <= pick;
          len <= src_len[12*pick +: 12];
          reads_left <= src_len[12*pick +: 12];
          writes_left <= src_len[12*pick +: 12];
          starve <= '0;
          pad <= 1'b0;
          state <= HDR;
        end
        HDR: if (wr) state <= LEN;
        LEN: if (wr) state <= len == 12'd0 ? TRL : PAY;
        PAY: if (wr) begin
          writes_left <= writes_left - 12'd1;
          if (writes_left == 12'd1) state <= TRL;
        end
        TRL: if (wr) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_packet_arbiter.sv
// tb_tx_packet_arbiter: directed checks of framing, round robin, backpressure, zero length, timeout and reset
module tb_tx_packet_arbiter;
  logic clk = 1'b0, rst = 1'b1, out_full = 1'b0;
  logic [2:0] src_req = '0, src_empty, src_rd_en, src_valid = '0, src_done;
  logic [35:0] src_len = '0;
  logic [47:0] src_data = '0;
  logic out_wr_en, busy, err_timeout;
  logic [15:0] out_data;
  logic [15:0] mem [3][64];
  int wr_cnt [3] = '{default: 0};
  int rd_ptr [3] = '{default: 0};
  int rd_cnt [3] = '{default: 0};
  int done_cnt [3] = '{default: 0};
  logic [15:0] wq [$];
  logic [15:0] exp_q [$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  tx_packet_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_len(src_len), .src_empty(src_empty),
    .src_rd_en(src_rd_en), .src_valid(src_valid), .src_data(src_data), .src_done(src_done),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_data(out_data), .busy(busy),
    .err_timeout(err_timeout)
  );
  always_comb for (int i = 0; i < 3; i++) src_empty[i] = rd_ptr[i] == wr_cnt[i];
  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      src_valid[i] <= src_rd_en[i];
      if (src_rd_en[i]) begin
        src_data[16*i +: 16] <= mem[i][rd_ptr[i] % 64];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  always @(negedge clk) begin
    if (out_wr_en) wq.push_back(out_data);
    for (int i = 0; i < 3; i++) begin
      rd_cnt[i] += int'(src_rd_en[i]);
      done_cnt[i] += int'(src_done[i]);
    end
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic load(int s, logic [15:0] w);
    mem[s][wr_cnt[s] % 64] = w;
    wr_cnt[s]++;
  endtask
  task automatic req(int s, logic [11:0] l);
    src_len[12*s +: 12] = l;
    src_req[s] = 1'b1;
  endtask
  task automatic wait_done(int s, int budget);
    int k = 0;
    while (!src_done[s] && k < budget) begin
      tick();
      k++;
    end
    chk($sformatf("done%0d_seen", s), 32'(src_done[s]), 32'd1);
    src_req[s] = 1'b0;
  endtask
  task automatic chk_seq(string tag, int base);
    chk({tag, "_count"}, 32'(wq.size() - base), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("%s_w%0d", tag, k), {16'h0, (base + k < wq.size()) ? wq[base + k] : 16'hxxxx}, {16'h0, exp_q[k]});
  endtask
  initial begin
    int b, r, d, k, w0;
    logic [15:0] held;
    tick(3);
    chk("rst_wr_en", 32'(out_wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(src_rd_en), 0);
    chk("rst_done", 32'(src_done), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst = 1'b0;
    // single packet
    for (int i = 1; i <= 4; i++) load(0, 16'(i));
    b = wq.size(); r = rd_cnt[0]; d = done_cnt[0];
    req(0, 12'd4);
    wait_done(0, 100);
    tick(2);
    exp_q = '{16'hA5A0, 16'h0004, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h5A5A};
    chk_seq("single", b);
    chk("single_rd", 32'(rd_cnt[0] - r), 4);
    chk("single_done", 32'(done_cnt[0] - d), 1);
    chk("single_idle", 32'(busy), 0);
    // round robin from reset, src0 re-requests during src2's packet
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    load(0, 16'h0010); load(1, 16'h0020); load(2, 16'h0030); load(0, 16'h0040);
    b = wq.size();
    req(0, 12'd1); req(1, 12'd1); req(2, 12'd1);
    wait_done(0, 50);
    wait_done(1, 50);
    req(0, 12'd1);
    wait_done(2, 50);
    wait_done(0, 50);
    exp_q = '{16'hA5A0, 16'h0001, 16'h0010, 16'h5A5A, 16'hA5A1, 16'h0001, 16'h0020, 16'h5A5A,
              16'hA5A2, 16'h0001, 16'h0030, 16'h5A5A, 16'hA5A0, 16'h0001, 16'h0040, 16'h5A5A};
    chk_seq("rr", b);
    // backpressure mid-payload
    for (int i = 1; i <= 6; i++) load(0, 16'h0100 + 16'(i));
    b = wq.size(); r = rd_cnt[0];
    req(0, 12'd6);
    k = 0;
    while (rd_cnt[0] - r < 2 && k < 50) begin
      tick();
      k++;
    end
    out_full = 1'b1;
    w0 = wq.size(); d = rd_cnt[0];
    tick(3);
    held = out_data;
    tick(7);
    chk("bp_data_frozen", 32'(out_data), 32'(held));
    chk("bp_no_write", 32'(wq.size() - w0), 0);
    chk("bp_rd_bounded", 32'(rd_cnt[0] - d <= 1), 1);
    out_full = 1'b0;
    wait_done(0, 100);
    exp_q = '{16'hA5A0, 16'h0006, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h5A5A};
    chk_seq("bp", b);
    chk("bp_rd_total", 32'(rd_cnt[0] - r), 6);
    // zero length
    b = wq.size(); r = rd_cnt[1];
    req(1, 12'd0);
    wait_done(1, 50);
    exp_q = '{16'hA5A1, 16'h0000, 16'h5A5A};
    chk_seq("zero", b);
    chk("zero_rd", 32'(rd_cnt[1] - r), 0);
    // starvation timeout with padding
    load(2, 16'h0201); load(2, 16'h0202);
    b = wq.size(); r = rd_cnt[2];
    req(2, 12'd5);
    wait_done(2, 300);
    exp_q = '{16'hA5A2, 16'h0005, 16'h0201, 16'h0202, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'h5A5B};
    chk_seq("tmo", b);
    chk("tmo_rd", 32'(rd_cnt[2] - r), 2);
    chk("tmo_err", 32'(err_timeout), 1);
    tick(5);
    chk("tmo_err_sticky", 32'(err_timeout), 1);
    // reset mid-payload, then all three request; source 0 must win
    load(1, 16'h0301);
    req(1, 12'd4);
    tick(12);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wr_en", 32'(out_wr_en), 0);
    chk("mid_rst_rd_en", 32'(src_rd_en), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_err", 32'(err_timeout), 0);
    load(0, 16'h0401); load(1, 16'h0402); load(2, 16'h0403);
    req(0, 12'd1); req(1, 12'd1); req(2, 12'd1);
    b = wq.size();
    rst = 1'b0;
    wait_done(0, 50);
    exp_q = '{16'hA5A0, 16'h0001, 16'h0401, 16'h5A5A};
    chk_seq("post_rst", b);
    wait_done(1, 50);
    wait_done(2, 50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
